// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch unit: state encoding, opcodes
// and the branch-offset helper.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_ERROR = 2'd3
    } fetch_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Sign-extended word offset converted to a byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_pc_next.sv
// Combinational next-PC selection: sequential PC+4 or taken branch target.
module pc_next
    import instr_fetch_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [15:0] i_imm,
    input  logic        i_branch,
    input  logic        i_zero,
    output logic [31:0] o_pc_next
);

    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_target;

    assign w_pc_plus4      = i_pc + 32'd4;
    assign w_branch_target = w_pc_plus4 + branch_offset(i_imm);
    assign o_pc_next       = (i_branch & i_zero) ? w_branch_target : w_pc_plus4;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory read, holds the fetched word
// until the consumer accepts it, and traps into ERROR on an ack timeout.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    output logic [31:0] Instr,
    output logic [5:0]  Opcode,
    output logic        InstrValid,
    input  logic        InstrReady,
    input  logic        Branch,
    input  logic        Zero,
    output logic [31:0] InstrCount,
    output logic        FetchErr
);

    localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);

    fetch_state_t     r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic             r_req;
    logic             r_valid;
    logic [31:0]      r_count;
    logic             r_err;
    logic [TMO_W-1:0] r_tmo;

    logic [31:0]      w_pc_next;
    logic [TMO_W-1:0] w_tmo_next;
    logic             w_tmo_hit;
    logic             w_accept;

    pc_next u_pc_next (
        .i_pc      (r_pc),
        .i_imm     (r_instr[15:0]),
        .i_branch  (Branch),
        .i_zero    (Zero),
        .o_pc_next (w_pc_next)
    );

    assign w_tmo_next = r_tmo + TMO_W'(1);
    assign w_tmo_hit  = (w_tmo_next == TMO_W'(ACK_TIMEOUT));
    assign w_accept   = r_valid & InstrReady;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= '0;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
            r_count <= '0;
            r_err   <= 1'b0;
            r_tmo   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_FETCH;
                    r_req   <= 1'b1;
                    r_tmo   <= '0;
                end
                ST_FETCH: begin
                    // An ack in the timeout cycle still completes the fetch.
                    if (IMemAck) begin
                        r_instr <= IMemData;
                        r_valid <= 1'b1;
                        r_req   <= 1'b0;
                        r_state <= ST_HOLD;
                    end else if (w_tmo_hit) begin
                        r_tmo   <= w_tmo_next;
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= ST_ERROR;
                    end else begin
                        r_tmo   <= w_tmo_next;
                    end
                end
                ST_HOLD: begin
                    if (w_accept) begin
                        r_pc    <= w_pc_next;
                        r_count <= r_count + 32'd1;
                        r_valid <= 1'b0;
                        r_req   <= 1'b1;
                        r_tmo   <= '0;
                        r_state <= ST_FETCH;
                    end
                end
                ST_ERROR: begin
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                    r_err   <= 1'b1;
                end
                default: begin
                    r_state <= ST_ERROR;
                end
            endcase
        end
    end

    assign IMemReq    = r_req;
    assign IMemAddr   = r_pc;
    assign Instr      = r_instr;
    assign Opcode     = r_instr[31:26];
    assign InstrValid = r_valid;
    assign InstrCount = r_count;
    assign FetchErr   = r_err;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: one instance at default
// parameters, one at a wrapping RESET_PC with a short ack timeout.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst_n, a_req, a_ack, a_valid, a_ready, a_branch, a_zero, a_err;
    logic [31:0] a_addr, a_data, a_instr, a_count;
    logic [5:0]  a_opcode;

    logic        b_rst_n, b_req, b_ack, b_valid, b_ready, b_branch, b_zero, b_err;
    logic [31:0] b_addr, b_data, b_instr, b_count;
    logic [5:0]  b_opcode;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    instr_fetch u_dut_a (
        .clk        (clk),
        .rst_n      (a_rst_n),
        .IMemReq    (a_req),
        .IMemAddr   (a_addr),
        .IMemAck    (a_ack),
        .IMemData   (a_data),
        .Instr      (a_instr),
        .Opcode     (a_opcode),
        .InstrValid (a_valid),
        .InstrReady (a_ready),
        .Branch     (a_branch),
        .Zero       (a_zero),
        .InstrCount (a_count),
        .FetchErr   (a_err)
    );

    instr_fetch #(
        .RESET_PC    (32'hFFFF_FFFC),
        .ACK_TIMEOUT (4)
    ) u_dut_b (
        .clk        (clk),
        .rst_n      (b_rst_n),
        .IMemReq    (b_req),
        .IMemAddr   (b_addr),
        .IMemAck    (b_ack),
        .IMemData   (b_data),
        .Instr      (b_instr),
        .Opcode     (b_opcode),
        .InstrValid (b_valid),
        .InstrReady (b_ready),
        .Branch     (b_branch),
        .Zero       (b_zero),
        .InstrCount (b_count),
        .FetchErr   (b_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        a_rst_n = 1'b1; a_ack = 1'b0; a_data = '0; a_ready = 1'b0; a_branch = 1'b0; a_zero = 1'b0;
        b_rst_n = 1'b1; b_ack = 1'b0; b_data = '0; b_ready = 1'b0; b_branch = 1'b0; b_zero = 1'b0;
        #2;
        a_rst_n = 1'b0;
        b_rst_n = 1'b0;
        #1;
        check("rst_req",   32'(a_req),   32'd0);
        check("rst_addr",  a_addr,       32'h0);
        check("rst_instr", a_instr,      32'h0);
        check("rst_valid", 32'(a_valid), 32'd0);
        check("rst_count", a_count,      32'd0);
        check("rst_err",   32'(a_err),   32'd0);
        check("rst_addr_b", b_addr,      32'hFFFF_FFFC);
        tick();
        tick();

        // First fetch, ack two cycles after the request appears
        a_rst_n = 1'b1;
        tick();
        check("f0_req",   32'(a_req),   32'd1);
        check("f0_addr",  a_addr,       32'h0);
        check("f0_valid", 32'(a_valid), 32'd0);
        tick();
        a_ack = 1'b1; a_data = 32'h8C01_0004;
        tick();
        a_ack = 1'b0;
        check("f0_valid_after_ack", 32'(a_valid), 32'd1);
        check("f0_opcode", 32'(a_opcode), 32'(OP_LW));
        check("f0_instr",  a_instr,       32'h8C01_0004);
        check("f0_req_hold", 32'(a_req),  32'd0);

        // Stall in HOLD; stray ack/branch/zero must be ignored
        a_ack = 1'b1; a_data = 32'hFFFF_FFFF; a_branch = 1'b1; a_zero = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_instr", a_instr,      32'h8C01_0004);
            check("stall_req",   32'(a_req),   32'd0);
            check("stall_valid", 32'(a_valid), 32'd1);
        end
        a_ack = 1'b0; a_zero = 1'b0; a_ready = 1'b1;
        tick();
        a_ready = 1'b0; a_branch = 1'b0;
        check("nt_addr",  a_addr,       32'h4);
        check("nt_req",   32'(a_req),   32'd1);
        check("nt_valid", 32'(a_valid), 32'd0);
        check("nt_count", a_count,      32'd1);
        check("nt_instr_kept", a_instr, 32'h8C01_0004);

        // PC 4: beq +2 taken -> 4+4+8 = 0x10
        a_ack = 1'b1; a_data = 32'h1000_0002;
        tick();
        a_ack = 1'b0;
        check("b1_opcode", 32'(a_opcode), 32'(OP_BEQ));
        a_ready = 1'b1; a_branch = 1'b1; a_zero = 1'b1;
        tick();
        a_ready = 1'b0; a_branch = 1'b0; a_zero = 1'b0;
        check("b1_addr",  a_addr,  32'h10);
        check("b1_count", a_count, 32'd2);

        // PC 0x10: beq -2 taken -> 0x14-8 = 0x0C
        a_ack = 1'b1; a_data = 32'h1000_FFFE;
        tick();
        a_ack = 1'b0;
        a_ready = 1'b1; a_branch = 1'b1; a_zero = 1'b1;
        tick();
        a_branch = 1'b0; a_zero = 1'b0;
        check("b2_addr",  a_addr,     32'h0C);
        check("b2_count", a_count,    32'd3);
        check("b2_req",   32'(a_req), 32'd1);

        // No ack: 15 more FETCH edges stay in FETCH, the 16th times out
        for (int i = 0; i < 15; i++) begin
            tick();
            a_ready = 1'b0;
        end
        check("tmo_early_err",   32'(a_err),  32'd0);
        check("tmo_early_req",   32'(a_req),  32'd1);
        check("tmo_early_count", a_count,     32'd3);
        tick();
        check("tmo_err",   32'(a_err),   32'd1);
        check("tmo_req",   32'(a_req),   32'd0);
        check("tmo_valid", 32'(a_valid), 32'd0);
        a_ack = 1'b1; a_ready = 1'b1;
        tick();
        tick();
        a_ack = 1'b0; a_ready = 1'b0;
        check("err_sticky", 32'(a_err),   32'd1);
        check("err_req",    32'(a_req),   32'd0);
        check("err_valid",  32'(a_valid), 32'd0);
        check("err_count",  a_count,      32'd3);

        // Asynchronous clear, mid-cycle
        a_rst_n = 1'b0;
        #1;
        check("arst_err",   32'(a_err), 32'd0);
        check("arst_addr",  a_addr,     32'h0);
        check("arst_count", a_count,    32'd0);
        check("arst_req",   32'(a_req), 32'd0);
        tick();
        tick();

        // Reset mid-FETCH, late ack right after release is discarded
        a_rst_n = 1'b1;
        tick();
        tick();
        check("mf_req", 32'(a_req), 32'd1);
        #2;
        a_rst_n = 1'b0;
        #1;
        check("mf_req_drop", 32'(a_req), 32'd0);
        tick();
        a_rst_n = 1'b1; a_ack = 1'b1; a_data = 32'hDEAD_BEEF;
        tick();
        a_ack = 1'b0;
        check("late_addr",  a_addr,       32'h0);
        check("late_valid", 32'(a_valid), 32'd0);
        check("late_instr", a_instr,      32'h0);
        check("late_req",   32'(a_req),   32'd1);
        tick();
        check("late_valid2", 32'(a_valid), 32'd0);
        check("late_instr2", a_instr,      32'h0);

        // Instance B: ack on the timeout edge wins, then PC wraps
        b_rst_n = 1'b1;
        tick();
        check("b_f0_addr", b_addr,     32'hFFFF_FFFC);
        check("b_f0_req",  32'(b_req), 32'd1);
        tick(); tick(); tick();
        check("b_pre_tmo_err", 32'(b_err), 32'd0);
        b_ack = 1'b1; b_data = 32'h0000_0020;
        tick();
        b_ack = 1'b0;
        check("b_ackwin_valid",  32'(b_valid),  32'd1);
        check("b_ackwin_err",    32'(b_err),    32'd0);
        check("b_ackwin_opcode", 32'(b_opcode), 32'(OP_RTYPE));
        check("b_ackwin_instr",  b_instr,       32'h0000_0020);
        b_ready = 1'b1; b_zero = 1'b1;
        tick();
        b_ready = 1'b0; b_zero = 1'b0;
        check("b_wrap_addr",  b_addr,  32'h0);
        check("b_wrap_count", b_count, 32'd1);
        b_ack = 1'b1; b_data = 32'h1000_FFFE;
        tick();
        b_ack = 1'b0;
        b_ready = 1'b1; b_branch = 1'b1; b_zero = 1'b1;
        tick();
        b_ready = 1'b0; b_branch = 1'b0; b_zero = 1'b0;
        check("b_tgt_wrap_addr",  b_addr,  32'hFFFF_FFFC);
        check("b_tgt_wrap_count", b_count, 32'd2);

        // Instance B: exactly ACK_TIMEOUT=4 FETCH edges without ack
        tick(); tick(); tick();
        check("b_tmo_early", 32'(b_err), 32'd0);
        tick();
        check("b_tmo_err", 32'(b_err), 32'd1);
        check("b_tmo_req", 32'(b_req), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address of the first fetched instruction, word-aligned.
REQ-002 Parameter ACK_TIMEOUT, default 16, maximum cycles a fetch waits for IMemAck before error.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 IMemReq  out  1  instruction-memory read request, held until IMemAck.
REQ-006 IMemAddr  out  32  byte address of the requested word; bits [1:0] always 0.
REQ-007 IMemAck  in  1  memory response strobe; IMemData valid this cycle.
REQ-008 IMemData  in  32  instruction word from memory.
REQ-009 Instr  out  32  held instruction word.
REQ-010 Opcode  out  6  Instr[31:26], driven to the main decoder.
REQ-011 InstrValid  out  1  Instr/Opcode hold a fetched, not-yet-accepted instruction.
REQ-012 InstrReady  in  1  consumer accepts Instr when InstrValid=1.
REQ-013 Branch  in  1  decoder branch control for the instruction being accepted.
REQ-014 Zero  in  1  ULA zero flag for the instruction being accepted.
REQ-015 InstrCount  out  32  number of accepted instructions.
REQ-016 FetchErr  out  1  sticky fetch-timeout flag.

Function
REQ-017 States: IDLE, FETCH, HOLD, ERROR.
REQ-018 IDLE: all request and valid outputs low. Move to FETCH on the first clock edge after rst_n deasserts.
REQ-019 FETCH: IMemReq=1, IMemAddr=PC. On IMemAck=1, register IMemData into Instr and move to HOLD. InstrValid rises the next cycle (1-cycle latency from ack).
REQ-020 HOLD: InstrValid=1, IMemReq=0. Instr stays stable until accepted. Accept occurs when InstrValid&InstrReady.
REQ-021 On accept: PC <= (Branch&Zero) ? PC+4+(sext(Instr[15:0])<<2) : PC+4. InstrCount increments by 1. State returns to FETCH. The new IMemReq/IMemAddr appear the cycle after accept.
REQ-022 Branch and Zero are sampled only on the accept cycle and ignored otherwise.
REQ-023 InstrValid falls on the cycle after accept. Instr retains its old value until the next ack.
REQ-024 PC and target arithmetic are modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0. Branch targets wrap identically.
REQ-025 IMemAck is ignored outside FETCH. InstrReady is ignored outside HOLD.
REQ-026 At most one outstanding request; no speculative fetch.
REQ-027 Timeout counter clears on FETCH entry and increments each FETCH cycle without ack.
REQ-028 When the timeout counter reaches ACK_TIMEOUT with no ack, move to ERROR.
REQ-029 ERROR: FetchErr=1, IMemReq=0, InstrValid=0. ERROR is left only by reset.
REQ-030 If the timeout is reached in the same cycle IMemAck=1, the ack wins and the block enters HOLD.
REQ-031 InstrCount wraps from 32'hFFFF_FFFF to 0.

Reset
REQ-032 While rst_n=0, asynchronously and independent of clk: state=IDLE, PC=RESET_PC, IMemReq=0, IMemAddr=RESET_PC, Instr=0, InstrValid=0, InstrCount=0, FetchErr=0, timeout counter=0.
REQ-033 Reset mid-FETCH drops IMemReq immediately. A late IMemAck arriving after reset release, while in IDLE, is discarded.

Structure
REQ-034 The shared package holds:
  - state encoding;
  - opcode constants OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100;
  - default RESET_PC.
REQ-035 One sub-module, pc_next: combinational next-PC and branch-target computation from PC, Instr[15:0], Branch, Zero.

Verification
REQ-036 Reset release, memory acks 2 cycles after request with 32'h8C01_0004 -> IMemAddr=0, InstrValid=1 one cycle after ack, Opcode=6'b100011.
REQ-037 Accept with Branch=1, Zero=1, Instr[15:0]=16'hFFFE at PC=32'h10 -> next IMemAddr=32'h0C, InstrCount=1.
REQ-038 Accept with Branch=1, Zero=0 -> next IMemAddr=PC+4. Hold InstrReady=0 for 5 cycles -> Instr stable, no new request.
REQ-039 No ack for ACK_TIMEOUT cycles -> FetchErr=1, IMemReq=0; stays set until rst_n pulse.
REQ-040 Reset asserted mid-FETCH, ack arriving 1 cycle after release -> discarded, IMemAddr=RESET_PC, InstrValid=0.
REQ-041 RESET_PC=32'hFFFF_FFFC, accept non-branch -> next IMemAddr=32'h0000_0000.
